// File: rtl/eth_rx_demux.sv
// eth_rx_demux: Ethernet receive demultiplexer with MAC filter and EtherType channel select.
// Parses the 14-byte header, then forwards the payload through one registered stage
// to the channel whose EtherType matches. Frames that fail the filter, runts and
// stalled headers are dropped and counted.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   local_mac_addr_in           station MAC (byte 0 of the frame is the MSB)
//   promisc_in                  accept any destination MAC
//   s_axis_t{data,valid,last}   frame byte stream from the MAC; s_axis_tready back-pressures it
//   m_axis_t{data,valid,last}   per-channel payload stream (channel k data at [8k+7:8k])
//   m_axis_tready               per-channel downstream ready
//   frame_drop_o                one-cycle pulse per dropped frame
//   drop_cnt_o                  saturating dropped-frame count
module eth_rx_demux #(
    parameter int                   NUM_CH     = 2,
    parameter logic [NUM_CH*16-1:0] ETYPE_LIST = {16'h0806, 16'h0800},
    parameter int                   TIMEOUT_W  = 12,
    parameter int                   DROP_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [47:0]           local_mac_addr_in,
    input  logic                  promisc_in,
    input  logic [7:0]            s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic [NUM_CH*8-1:0]   m_axis_tdata,
    output logic [NUM_CH-1:0]     m_axis_tvalid,
    output logic [NUM_CH-1:0]     m_axis_tlast,
    input  logic [NUM_CH-1:0]     m_axis_tready,
    output logic                  frame_drop_o,
    output logic [DROP_CNT_W-1:0] drop_cnt_o
);
    localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {HDR, FWD, DISCARD} state_t;

    state_t                r_state, w_state_nxt;
    logic [3:0]            r_hcnt, w_hcnt_nxt;
    logic [47:0]           r_dest;
    logic [7:0]            r_et_hi;
    logic [SEL_W-1:0]      r_sel, w_ch;
    logic                  r_out_valid, r_out_last;
    logic [7:0]            r_out_data;
    logic [TIMEOUT_W-1:0]  r_tmo;
    logic                  r_drop;
    logic [DROP_CNT_W-1:0] r_drop_cnt;
    logic                  w_ready, w_beat, w_sel_rdy, w_hit, w_dest_ok, w_accept;
    logic                  w_tmo_act, w_tmo_exp, w_drop;
    logic [15:0]           w_etype;

    assign w_sel_rdy = m_axis_tready[r_sel];
    assign w_etype   = {r_et_hi, s_axis_tdata};
    assign w_dest_ok = (r_dest == local_mac_addr_in) | (&r_dest) | promisc_in;
    assign w_accept  = w_dest_ok & w_hit & !s_axis_tlast;

    // The last header byte waits until the previous frame's final byte has left
    // the output register, so r_sel never changes under a pending beat.
    assign w_ready = reset ? 1'b0 :
                     (r_state == FWD) ? (!r_out_valid | w_sel_rdy) :
                     (r_state == HDR && r_hcnt == 4'd13) ? !r_out_valid : 1'b1;
    assign w_beat        = s_axis_tvalid & w_ready;
    assign s_axis_tready = w_ready;

    // Expiry fires on the idle cycle that would bring the count to all-ones.
    assign w_tmo_act = (r_state == HDR && r_hcnt != 4'd0) || r_state == DISCARD;
    assign w_tmo_exp = w_tmo_act & !w_beat & (r_tmo == {{(TIMEOUT_W-1){1'b1}}, 1'b0});

    // Lowest-numbered matching channel wins.
    always_comb begin
        w_hit = 1'b0;
        w_ch  = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (w_etype == ETYPE_LIST[16*k +: 16]) begin
                w_hit = 1'b1;
                w_ch  = SEL_W'(k);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_hcnt_nxt  = r_hcnt;
        w_drop      = 1'b0;
        case (r_state)
            HDR: begin
                if (w_beat) begin
                    if (r_hcnt == 4'd13) begin
                        w_hcnt_nxt = 4'd0;
                        w_drop     = !w_accept;
                        w_state_nxt = w_accept ? FWD : (s_axis_tlast ? HDR : DISCARD);
                    end else begin
                        w_drop     = s_axis_tlast;
                        w_hcnt_nxt = s_axis_tlast ? 4'd0 : r_hcnt + 4'd1;
                    end
                end else if (w_tmo_exp) begin
                    w_drop     = 1'b1;
                    w_hcnt_nxt = 4'd0;
                end
            end
            FWD: w_state_nxt = (w_beat && s_axis_tlast) ? HDR : FWD;
            DISCARD: begin
                w_drop      = w_tmo_exp;
                w_state_nxt = ((w_beat && s_axis_tlast) || w_tmo_exp) ? HDR : DISCARD;
            end
            default: w_state_nxt = HDR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= HDR;
            r_hcnt      <= 4'd0;
            r_dest      <= '0;
            r_et_hi     <= '0;
            r_sel       <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
            r_tmo       <= '0;
            r_drop      <= 1'b0;
            r_drop_cnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_hcnt  <= w_hcnt_nxt;
            r_drop  <= w_drop;
            if (w_drop && r_drop_cnt != '1)
                r_drop_cnt <= r_drop_cnt + 1'b1;
            r_tmo <= (!w_tmo_act || w_beat || w_tmo_exp || w_state_nxt != r_state) ? '0 : r_tmo + 1'b1;
            if (r_state == HDR && w_beat) begin
                if (r_hcnt < 4'd6)
                    r_dest <= {r_dest[39:0], s_axis_tdata};
                if (r_hcnt == 4'd12)
                    r_et_hi <= s_axis_tdata;
                if (r_hcnt == 4'd13 && w_accept)
                    r_sel <= w_ch;
            end
            if (r_state == FWD && w_beat) begin
                r_out_valid <= 1'b1;
                r_out_data  <= s_axis_tdata;
                r_out_last  <= s_axis_tlast;
            end else if (w_sel_rdy) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        assign m_axis_tvalid[k]       = r_out_valid && (r_sel == SEL_W'(k));
        assign m_axis_tlast[k]        = r_out_valid && r_out_last && (r_sel == SEL_W'(k));
        assign m_axis_tdata[8*k +: 8] = (r_sel == SEL_W'(k)) ? r_out_data : 8'd0;
    end

    assign frame_drop_o = r_drop;
    assign drop_cnt_o   = r_drop_cnt;
endmodule

// File: tb/tb_eth_rx_demux.sv
// tb_eth_rx_demux: directed bench for eth_rx_demux with default parameters.
module tb_eth_rx_demux;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [47:0] mac = 48'h02_00_00_00_00_01;
    logic        promisc = 1'b0;
    logic [7:0]  s_tdata = 8'd0;
    logic        s_tvalid = 1'b0;
    logic        s_tlast = 1'b0;
    logic        s_tready;
    logic [15:0] m_tdata;
    logic [1:0]  m_tvalid, m_tlast;
    logic [1:0]  m_tready = 2'b11;
    logic        drop;
    logic [15:0] dcnt;

    int total = 0, bad = 0, drops = 0, exp_cnt = 0, st_err = 0, st_seen = 0, vc0 = 0, vc1 = 0;
    logic [7:0] fr[$];
    logic [8:0] cap0[$], cap1[$];

    eth_rx_demux dut (
        .clk(clk), .reset(reset), .local_mac_addr_in(mac), .promisc_in(promisc),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
        .frame_drop_o(drop), .drop_cnt_o(dcnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (m_tvalid[0] === 1'b1) vc0++;
        if (m_tvalid[1] === 1'b1) vc1++;
        if (m_tvalid[0] === 1'b1 && m_tready[0]) cap0.push_back({m_tlast[0], m_tdata[7:0]});
        if (m_tvalid[1] === 1'b1 && m_tready[1]) cap1.push_back({m_tlast[1], m_tdata[15:8]});
        if (drop === 1'b1) drops++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, required finish before 1ms");
        $fatal(1);
    end

    task automatic mk(input logic [47:0] dst, input logic [15:0] et, input int n, input logic [7:0] base);
        fr.delete();
        for (int i = 0; i < 6; i++) fr.push_back(dst[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) fr.push_back(8'hA5);
        fr.push_back(et[15:8]);
        fr.push_back(et[7:0]);
        for (int i = 0; i < n; i++) fr.push_back(8'(base + i));
    endtask

    task automatic send(input bit no_last, input int lat_ch, input int st_ch);
        logic rdy;
        int n;
        for (int i = 0; i < fr.size(); i++) begin
            s_tdata  = fr[i];
            s_tvalid = 1'b1;
            s_tlast  = !no_last && (i == fr.size() - 1);
            n = 0;
            do begin
                @(negedge clk);
                rdy = s_tready;
                if (st_ch >= 0 && i >= 14) begin
                    if (!rdy) st_seen++;
                    if (rdy !== (!m_tvalid[st_ch] || m_tready[st_ch])) st_err++;
                end
                @(posedge clk);
                n++;
            end while (!rdy && n < 100);
            #1;
            if (!rdy) begin
                total++; bad++;
                $display("FAIL send_stuck byte %0d: s_axis_tready=0 for 100 cycles, required 1", i);
                s_tvalid = 1'b0;
                s_tlast  = 1'b0;
                return;
            end
            if (lat_ch >= 0 && i >= 14) begin
                total++;
                if (m_tvalid[lat_ch] !== 1'b1 || m_tdata[lat_ch*8 +: 8] !== fr[i]) begin
                    bad++;
                    $display("FAIL latency byte %0d: valid=%b data=%h required valid=1 data=%h",
                             i, m_tvalid[lat_ch], m_tdata[lat_ch*8 +: 8], fr[i]);
                end
            end
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (s_tready !== 1'b0 || m_tvalid !== 2'b00 || m_tlast !== 2'b00 || m_tdata !== 16'h0 ||
            drop !== 1'b0 || dcnt !== 16'h0) begin
            bad++;
            $display("FAIL reset_values: rdy=%b v=%b l=%b d=%h drop=%b cnt=%0d required 0 0 0 0 0 0",
                     s_tready, m_tvalid, m_tlast, m_tdata, drop, dcnt);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (s_tready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_ready: got %b required 1", s_tready);
        end
    endtask

    task automatic test_unicast;
        logic [8:0] e;
        cap0.delete(); cap1.delete();
        vc1 = 0;
        mk(mac, 16'h0800, 20, 8'h00);
        send(0, 0, -1);
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (cap0.size() !== 20) begin
            bad++;
            $display("FAIL unicast_count: got %0d required 20", cap0.size());
        end
        for (int i = 0; i < 20; i++) begin
            e = {(i == 19), 8'(i)};
            total++;
            if (cap0[i] !== e) begin
                bad++;
                $display("FAIL unicast_byte %0d: got %h required %h", i, cap0[i], e);
            end
        end
        total++;
        if (vc1 !== 0 || dcnt !== 16'(exp_cnt)) begin
            bad++;
            $display("FAIL unicast_idle: ch1 valid cycles=%0d cnt=%0d required 0 and %0d", vc1, dcnt, exp_cnt);
        end
    endtask

    task automatic test_broadcast_stall;
        logic [8:0] e;
        bit done;
        done = 0;
        cap0.delete(); cap1.delete();
        st_err = 0; st_seen = 0;
        mk(48'hFFFF_FFFF_FFFF, 16'h0806, 28, 8'h20);
        fork
            begin
                send(0, -1, 1);
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    m_tready[1] = ~m_tready[1];
                end
            end
        join
        m_tready = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (cap1.size() !== 28 || cap0.size() !== 0) begin
            bad++;
            $display("FAIL stall_count: ch1=%0d ch0=%0d required 28 and 0", cap1.size(), cap0.size());
        end
        for (int i = 0; i < 28; i++) begin
            e = {(i == 27), 8'(8'h20 + i)};
            total++;
            if (cap1[i] !== e) begin
                bad++;
                $display("FAIL stall_byte %0d: got %h required %h", i, cap1[i], e);
            end
        end
        total++;
        if (st_err !== 0 || st_seen == 0) begin
            bad++;
            $display("FAIL stall_ready: mismatched cycles=%0d stalled cycles=%0d required 0 and >0", st_err, st_seen);
        end
    endtask

    task automatic test_promisc;
        logic [8:0] e;
        int d0;
        cap0.delete(); cap1.delete();
        d0 = drops;
        promisc = 1'b0;
        mk(48'h02_00_00_00_00_99, 16'h0800, 6, 8'h30);
        send(0, -1, -1);
        repeat (2) @(posedge clk);
        #1;
        exp_cnt++;
        total++;
        if (drops - d0 !== 1 || dcnt !== 16'(exp_cnt) || cap0.size() !== 0) begin
            bad++;
            $display("FAIL foreign_mac_drop: pulses=%0d cnt=%0d out=%0d required 1 %0d 0",
                     drops - d0, dcnt, cap0.size(), exp_cnt);
        end
        promisc = 1'b1;
        send(0, 0, -1);
        repeat (2) @(posedge clk);
        #1;
        promisc = 1'b0;
        total++;
        if (cap0.size() !== 6 || dcnt !== 16'(exp_cnt)) begin
            bad++;
            $display("FAIL promisc_fwd: out=%0d cnt=%0d required 6 and %0d", cap0.size(), dcnt, exp_cnt);
        end
        for (int i = 0; i < 6; i++) begin
            e = {(i == 5), 8'(8'h30 + i)};
            total++;
            if (cap0[i] !== e) begin
                bad++;
                $display("FAIL promisc_byte %0d: got %h required %h", i, cap0[i], e);
            end
        end
    endtask

    task automatic test_etype_runt;
        logic [8:0] e;
        int d0;
        cap0.delete(); cap1.delete();
        vc0 = 0; vc1 = 0;
        d0 = drops;
        mk(mac, 16'h86DD, 6, 8'h40);
        send(0, -1, -1);
        mk(mac, 16'h0800, 0, 8'h00);
        fr = fr[0:9];
        send(0, -1, -1);
        total++;
        if (drop !== 1'b1) begin
            bad++;
            $display("FAIL runt_pulse: frame_drop_o=%b required 1 the cycle after the runt tlast", drop);
        end
        repeat (2) @(posedge clk);
        #1;
        exp_cnt += 2;
        total++;
        if (drops - d0 !== 2 || dcnt !== 16'(exp_cnt) || vc0 !== 0 || vc1 !== 0) begin
            bad++;
            $display("FAIL etype_runt_drop: pulses=%0d cnt=%0d vc0=%0d vc1=%0d required 2 %0d 0 0",
                     drops - d0, dcnt, vc0, vc1, exp_cnt);
        end
        mk(mac, 16'h0806, 5, 8'h50);
        send(0, 1, -1);
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (cap1.size() !== 5 || cap0.size() !== 0) begin
            bad++;
            $display("FAIL after_drop_count: ch1=%0d ch0=%0d required 5 and 0", cap1.size(), cap0.size());
        end
        for (int i = 0; i < 5; i++) begin
            e = {(i == 4), 8'(8'h50 + i)};
            total++;
            if (cap1[i] !== e) begin
                bad++;
                $display("FAIL after_drop_byte %0d: got %h required %h", i, cap1[i], e);
            end
        end
    endtask

    task automatic test_timeout;
        logic [8:0] e;
        int n;
        cap0.delete(); cap1.delete();
        mk(mac, 16'h0800, 0, 8'h00);
        fr = fr[0:5];
        send(1, -1, -1);
        n = 0;
        while (drop !== 1'b1 && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        exp_cnt++;
        total++;
        if (drop !== 1'b1 || n < 4094 || n > 4096) begin
            bad++;
            $display("FAIL timeout_pulse: pulse=%b after %0d idle cycles required 1 after about 4095", drop, n);
        end
        total++;
        if (dcnt !== 16'(exp_cnt)) begin
            bad++;
            $display("FAIL timeout_cnt: got %0d required %0d", dcnt, exp_cnt);
        end
        mk(mac, 16'h0800, 4, 8'h60);
        send(0, 0, -1);
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (cap0.size() !== 4) begin
            bad++;
            $display("FAIL timeout_next_count: got %0d required 4", cap0.size());
        end
        for (int i = 0; i < 4; i++) begin
            e = {(i == 3), 8'(8'h60 + i)};
            total++;
            if (cap0[i] !== e) begin
                bad++;
                $display("FAIL timeout_next_byte %0d: got %h required %h", i, cap0[i], e);
            end
        end
    endtask

    task automatic test_reset_midframe;
        logic [8:0] e;
        m_tready[0] = 1'b0;
        mk(mac, 16'h0800, 3, 8'h70);
        fr = fr[0:14];
        send(1, -1, -1);
        total++;
        if (m_tvalid[0] !== 1'b1 || m_tdata[7:0] !== 8'h70) begin
            bad++;
            $display("FAIL midframe_hold: valid=%b data=%h required 1 and 70", m_tvalid[0], m_tdata[7:0]);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (m_tvalid !== 2'b00 || m_tlast !== 2'b00 || m_tdata !== 16'h0 || drop !== 1'b0 ||
            dcnt !== 16'h0 || s_tready !== 1'b0) begin
            bad++;
            $display("FAIL midframe_reset: v=%b l=%b d=%h drop=%b cnt=%0d rdy=%b required all 0",
                     m_tvalid, m_tlast, m_tdata, drop, dcnt, s_tready);
        end
        reset = 1'b0;
        exp_cnt = 0;
        m_tready[0] = 1'b1;
        cap0.delete(); cap1.delete();
        mk(mac, 16'h0800, 4, 8'h80);
        send(0, 0, -1);
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (cap0.size() !== 4 || cap1.size() !== 0 || dcnt !== 16'h0) begin
            bad++;
            $display("FAIL post_reset_count: ch0=%0d ch1=%0d cnt=%0d required 4 0 0", cap0.size(), cap1.size(), dcnt);
        end
        for (int i = 0; i < 4; i++) begin
            e = {(i == 3), 8'(8'h80 + i)};
            total++;
            if (cap0[i] !== e) begin
                bad++;
                $display("FAIL post_reset_byte %0d: got %h required %h", i, cap0[i], e);
            end
        end
    endtask

    initial begin
        test_reset;
        test_unicast;
        test_broadcast_stall;
        test_promisc;
        test_etype_runt;
        test_timeout;
        test_reset_midframe;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
